// File: rtl/racalc_arb_pkg.sv
// Shared types for the racalc job-descriptor stream merge.
// Holds payload widths, grant-FSM state and source encodings, and the job
// payload carried through the output register.
package racalc_arb_pkg;

    localparam int unsigned CNT_LS_W = 8;
    localparam int unsigned POS_W    = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_PDE  = 2'd1,
        LOCK_PDAE = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_PDE  = 1'b0,
        SRC_PDAE = 1'b1
    } src_t;

    typedef struct packed {
        logic [CNT_LS_W-1:0] cnt_ls;
        logic [POS_W-1:0]    pos;
        src_t                src;
    } job_t;

    // Round-robin partner of a source.
    function automatic src_t other_src(input src_t s);
        return (s == SRC_PDE) ? SRC_PDAE : SRC_PDE;
    endfunction

endpackage

// File: rtl/racalc_job_arbiter_if.sv
// FIFO handshake bundle of the job arbiter: two split (cnt_ls/pos) ap_fifo
// read ports for pde and pdae, and the split racalc_jobs write port plus
// its source tag.
//   master : arbiter side (drives read strobes, din and write strobes)
//   slave  : fifo side (drives dout/empty_n and full_n)
interface racalc_job_arbiter_if;
    import racalc_arb_pkg::*;

    logic [CNT_LS_W-1:0] pde_data_in_V_cnt_ls_V_dout;
    logic                pde_data_in_V_cnt_ls_V_empty_n;
    logic                pde_data_in_V_cnt_ls_V_read;
    logic [POS_W-1:0]    pde_data_in_V_pos_V_dout;
    logic                pde_data_in_V_pos_V_empty_n;
    logic                pde_data_in_V_pos_V_read;

    logic [CNT_LS_W-1:0] pdae_data_in_V_cnt_ls_V_dout;
    logic                pdae_data_in_V_cnt_ls_V_empty_n;
    logic                pdae_data_in_V_cnt_ls_V_read;
    logic [POS_W-1:0]    pdae_data_in_V_pos_V_dout;
    logic                pdae_data_in_V_pos_V_empty_n;
    logic                pdae_data_in_V_pos_V_read;

    logic [CNT_LS_W-1:0] racalc_jobs_V_cnt_ls_V_din;
    logic                racalc_jobs_V_cnt_ls_V_full_n;
    logic                racalc_jobs_V_cnt_ls_V_write;
    logic [POS_W-1:0]    racalc_jobs_V_pos_V_din;
    logic                racalc_jobs_V_pos_V_full_n;
    logic                racalc_jobs_V_pos_V_write;
    logic                racalc_jobs_V_src_V_din;

    modport master (
        input  pde_data_in_V_cnt_ls_V_dout, pde_data_in_V_cnt_ls_V_empty_n,
        output pde_data_in_V_cnt_ls_V_read,
        input  pde_data_in_V_pos_V_dout, pde_data_in_V_pos_V_empty_n,
        output pde_data_in_V_pos_V_read,
        input  pdae_data_in_V_cnt_ls_V_dout, pdae_data_in_V_cnt_ls_V_empty_n,
        output pdae_data_in_V_cnt_ls_V_read,
        input  pdae_data_in_V_pos_V_dout, pdae_data_in_V_pos_V_empty_n,
        output pdae_data_in_V_pos_V_read,
        output racalc_jobs_V_cnt_ls_V_din, racalc_jobs_V_cnt_ls_V_write,
        input  racalc_jobs_V_cnt_ls_V_full_n,
        output racalc_jobs_V_pos_V_din, racalc_jobs_V_pos_V_write,
        input  racalc_jobs_V_pos_V_full_n,
        output racalc_jobs_V_src_V_din
    );

    modport slave (
        output pde_data_in_V_cnt_ls_V_dout, pde_data_in_V_cnt_ls_V_empty_n,
        input  pde_data_in_V_cnt_ls_V_read,
        output pde_data_in_V_pos_V_dout, pde_data_in_V_pos_V_empty_n,
        input  pde_data_in_V_pos_V_read,
        output pdae_data_in_V_cnt_ls_V_dout, pdae_data_in_V_cnt_ls_V_empty_n,
        input  pdae_data_in_V_cnt_ls_V_read,
        output pdae_data_in_V_pos_V_dout, pdae_data_in_V_pos_V_empty_n,
        input  pdae_data_in_V_pos_V_read,
        input  racalc_jobs_V_cnt_ls_V_din, racalc_jobs_V_cnt_ls_V_write,
        output racalc_jobs_V_cnt_ls_V_full_n,
        input  racalc_jobs_V_pos_V_din, racalc_jobs_V_pos_V_write,
        output racalc_jobs_V_pos_V_full_n,
        input  racalc_jobs_V_src_V_din
    );

endinterface

// File: rtl/racalc_job_outreg.sv
// One-entry registered output stage for a job stream merge.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   load         capture job_in this cycle (caller guarantees can_load_c)
//   job_in       payload to capture
//   full_n       downstream can accept (all sink fifos ANDed)
//   valid        a word is held in job_out
//   job_out      held payload, stable while not written
//   write_c      word transfers downstream this cycle
//   can_load_c   register is free now or frees up this cycle
module racalc_job_outreg
    import racalc_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  job_t job_in,
    input  logic full_n,
    output logic valid,
    output job_t job_out,
    output logic write_c,
    output logic can_load_c
);

    assign write_c    = valid & full_n;
    // A write and a load in the same cycle keeps the stage full at 1 word/cycle.
    assign can_load_c = ~valid | write_c;

    // Holding register; payload only changes on load so din stays stable under back-pressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            job_out <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            job_out <= job_in;
        end else if (write_c) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/racalc_job_arbiter.sv
// Merges the pde and pdae job-descriptor streams into racalc_jobs with
// burst-level round-robin arbitration and a one-entry output register.
// Ports:
//   ap_clk, ap_rst_n   clock and synchronous active-low reset
//   ap_start           enables new burst grants (running bursts always finish)
//   ap_idle            no burst in progress and output register empty
//   bus                fifo handshakes (see racalc_job_arbiter_if)
//   pde_word_cnt       wrapping count of words read from pde
//   pdae_word_cnt      wrapping count of words read from pdae
module racalc_job_arbiter
    import racalc_arb_pkg::*;
#(
    parameter int unsigned LAST_BIT = 7,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    output logic                 ap_idle,
    racalc_job_arbiter_if.master bus,
    output logic [CNT_W-1:0]     pde_word_cnt,
    output logic [CNT_W-1:0]     pdae_word_cnt
);

    arb_state_t state_q, state_d;
    src_t       last_grant_q, last_grant_d;
    src_t       pick;

    logic pde_ready, pdae_ready;
    logic pde_last, pdae_last;
    logic rd_pde, rd_pdae;
    logic load;
    logic out_valid, out_write_c, can_load_c, full_n;
    job_t sel_job, out_job;

    // A source is only usable when both halves of its word are present.
    assign pde_ready  = bus.pde_data_in_V_cnt_ls_V_empty_n  & bus.pde_data_in_V_pos_V_empty_n;
    assign pdae_ready = bus.pdae_data_in_V_cnt_ls_V_empty_n & bus.pdae_data_in_V_pos_V_empty_n;
    assign pde_last   = bus.pde_data_in_V_cnt_ls_V_dout[LAST_BIT];
    assign pdae_last  = bus.pdae_data_in_V_cnt_ls_V_dout[LAST_BIT];
    assign full_n     = bus.racalc_jobs_V_cnt_ls_V_full_n & bus.racalc_jobs_V_pos_V_full_n;

    // Grant state register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_PDAE;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Grant next-state and read-strobe decode.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pick         = SRC_PDE;
        rd_pde       = 1'b0;
        rd_pdae      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ap_start && can_load_c && (pde_ready || pdae_ready)) begin
                    if (pde_ready && pdae_ready) begin
                        pick = other_src(last_grant_q);
                    end else begin
                        pick = pde_ready ? SRC_PDE : SRC_PDAE;
                    end
                    last_grant_d = pick;
                    if (pick == SRC_PDE) begin
                        rd_pde = 1'b1;
                        if (!pde_last) state_d = LOCK_PDE;
                    end else begin
                        rd_pdae = 1'b1;
                        if (!pdae_last) state_d = LOCK_PDAE;
                    end
                end
            end
            LOCK_PDE: begin
                if (can_load_c && pde_ready) begin
                    rd_pde = 1'b1;
                    if (pde_last) state_d = IDLE;
                end
            end
            LOCK_PDAE: begin
                if (can_load_c && pdae_ready) begin
                    rd_pdae = 1'b1;
                    if (pdae_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load = rd_pde | rd_pdae;

    // Payload mux for the word being read this cycle.
    always_comb begin
        sel_job = '0;
        if (rd_pdae) begin
            sel_job.cnt_ls = bus.pdae_data_in_V_cnt_ls_V_dout;
            sel_job.pos    = bus.pdae_data_in_V_pos_V_dout;
            sel_job.src    = SRC_PDAE;
        end else begin
            sel_job.cnt_ls = bus.pde_data_in_V_cnt_ls_V_dout;
            sel_job.pos    = bus.pde_data_in_V_pos_V_dout;
            sel_job.src    = SRC_PDE;
        end
    end

    racalc_job_outreg u_outreg (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .load       (load),
        .job_in     (sel_job),
        .full_n     (full_n),
        .valid      (out_valid),
        .job_out    (out_job),
        .write_c    (out_write_c),
        .can_load_c (can_load_c)
    );

    // Both halves of a source are always popped together.
    assign bus.pde_data_in_V_cnt_ls_V_read  = rd_pde;
    assign bus.pde_data_in_V_pos_V_read     = rd_pde;
    assign bus.pdae_data_in_V_cnt_ls_V_read = rd_pdae;
    assign bus.pdae_data_in_V_pos_V_read    = rd_pdae;

    assign bus.racalc_jobs_V_cnt_ls_V_write = out_write_c;
    assign bus.racalc_jobs_V_pos_V_write    = out_write_c;
    assign bus.racalc_jobs_V_cnt_ls_V_din   = out_job.cnt_ls;
    assign bus.racalc_jobs_V_pos_V_din      = out_job.pos;
    assign bus.racalc_jobs_V_src_V_din      = out_job.src;

    assign ap_idle = (state_q == IDLE) & ~out_valid;

    // Per-source forwarded-word counters, wrapping.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            pde_word_cnt  <= '0;
            pdae_word_cnt <= '0;
        end else begin
            if (rd_pde)  pde_word_cnt  <= pde_word_cnt  + CNT_W'(1);
            if (rd_pdae) pdae_word_cnt <= pdae_word_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_racalc_job_arbiter.sv
// Directed bench for racalc_job_arbiter: a per-cycle vector table plus
// hand-written reset and counter-wrap sequences.
module tb_racalc_job_arbiter;
    import racalc_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ap_start;
    logic        ap_idle;
    logic [15:0] pde_word_cnt, pdae_word_cnt;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    racalc_job_arbiter_if bus ();

    racalc_job_arbiter dut (
        .ap_clk        (clk),
        .ap_rst_n      (rst_n),
        .ap_start      (ap_start),
        .ap_idle       (ap_idle),
        .bus           (bus),
        .pde_word_cnt  (pde_word_cnt),
        .pdae_word_cnt (pdae_word_cnt)
    );

    // One cycle of stimulus and the outputs expected while it is applied.
    typedef struct packed {
        logic        st;
        logic [1:0]  pe;   // pde  {cnt_ls empty_n, pos empty_n}
        logic [7:0]  pc;
        logic [15:0] pp;
        logic [1:0]  qe;   // pdae {cnt_ls empty_n, pos empty_n}
        logic [7:0]  qc;
        logic [15:0] qp;
        logic [1:0]  fn;   // {cnt_ls full_n, pos full_n}
        logic        rp;
        logic        rq;
        logic        wr;
        logic [7:0]  oc;
        logic [15:0] op;
        logic        os;
        logic        idle;
        logic [15:0] cp;
        logic [15:0] cq;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mkv(
        input logic st, input logic [1:0] pe, input logic [7:0] pc, input logic [15:0] pp,
        input logic [1:0] qe, input logic [7:0] qc, input logic [15:0] qp, input logic [1:0] fn,
        input logic rp, input logic rq, input logic wr, input logic [7:0] oc, input logic [15:0] op,
        input logic os, input logic idle, input logic [15:0] cp, input logic [15:0] cq);
        vec_t v;
        v.st = st; v.pe = pe; v.pc = pc; v.pp = pp;
        v.qe = qe; v.qc = qc; v.qp = qp; v.fn = fn;
        v.rp = rp; v.rq = rq; v.wr = wr; v.oc = oc; v.op = op;
        v.os = os; v.idle = idle; v.cp = cp; v.cq = cq;
        return v;
    endfunction

    function automatic logic [63:0] expv(
        input logic rp, input logic rq, input logic wr, input logic [7:0] oc, input logic [15:0] op,
        input logic os, input logic idle, input logic [15:0] cp, input logic [15:0] cq);
        return {rp, rp, rq, rq, wr, wr, oc, op, os, idle, cp, cq};
    endfunction

    task automatic drive(input logic st, input logic [1:0] pe, input logic [7:0] pc, input logic [15:0] pp,
                         input logic [1:0] qe, input logic [7:0] qc, input logic [15:0] qp,
                         input logic [1:0] fn);
        ap_start = st;
        bus.pde_data_in_V_cnt_ls_V_empty_n  = pe[1];
        bus.pde_data_in_V_pos_V_empty_n     = pe[0];
        bus.pde_data_in_V_cnt_ls_V_dout     = pc;
        bus.pde_data_in_V_pos_V_dout        = pp;
        bus.pdae_data_in_V_cnt_ls_V_empty_n = qe[1];
        bus.pdae_data_in_V_pos_V_empty_n    = qe[0];
        bus.pdae_data_in_V_cnt_ls_V_dout    = qc;
        bus.pdae_data_in_V_pos_V_dout       = qp;
        bus.racalc_jobs_V_cnt_ls_V_full_n   = fn[1];
        bus.racalc_jobs_V_pos_V_full_n      = fn[0];
    endtask

    // Layout: {pde rd c/p, pdae rd c/p, wr c/p, din cnt_ls, din pos, src, idle, cnt pde, cnt pdae}
    task automatic check(input string name, input logic [63:0] exp);
        logic [63:0] got;
        got = {bus.pde_data_in_V_cnt_ls_V_read, bus.pde_data_in_V_pos_V_read,
               bus.pdae_data_in_V_cnt_ls_V_read, bus.pdae_data_in_V_pos_V_read,
               bus.racalc_jobs_V_cnt_ls_V_write, bus.racalc_jobs_V_pos_V_write,
               bus.racalc_jobs_V_cnt_ls_V_din, bus.racalc_jobs_V_pos_V_din,
               bus.racalc_jobs_V_src_V_din, ap_idle, pde_word_cnt, pdae_word_cnt};
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else             passed++;
    endtask

    task automatic idle_in();
        drive(1'b1, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 2'b11);
    endtask

    task automatic reset_for(input int n);
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_in();
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int nrd;
        rst_n = 1'b0;
        idle_in();

        // st pe pc pp | qe qc qp | fn || rp rq wr oc op os idle cp cq
        // Alternating single-word bursts.
        vecs[0]  = mkv(1'b1,2'b11,8'h81,16'h1000, 2'b00,8'h00,16'h0000, 2'b11, 1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd0,16'd0);
        vecs[1]  = mkv(1'b1,2'b00,8'h00,16'h0000, 2'b11,8'h82,16'h2000, 2'b11, 1'b0,1'b1,1'b1,8'h81,16'h1000,1'b0,1'b0,16'd1,16'd0);
        vecs[2]  = mkv(1'b1,2'b00,8'h00,16'h0000, 2'b00,8'h00,16'h0000, 2'b11, 1'b0,1'b0,1'b1,8'h82,16'h2000,1'b1,1'b0,16'd1,16'd1);
        vecs[3]  = mkv(1'b1,2'b00,8'h00,16'h0000, 2'b00,8'h00,16'h0000, 2'b11, 1'b0,1'b0,1'b0,8'h82,16'h2000,1'b1,1'b1,16'd1,16'd1);
        // Repeated ties alternate pde, pdae, pde.
        vecs[4]  = mkv(1'b1,2'b11,8'h80,16'h1111, 2'b11,8'h80,16'h2222, 2'b11, 1'b1,1'b0,1'b0,8'h82,16'h2000,1'b1,1'b1,16'd1,16'd1);
        vecs[5]  = mkv(1'b1,2'b11,8'h80,16'h1112, 2'b11,8'h80,16'h2222, 2'b11, 1'b0,1'b1,1'b1,8'h80,16'h1111,1'b0,1'b0,16'd2,16'd1);
        vecs[6]  = mkv(1'b1,2'b11,8'h80,16'h1113, 2'b11,8'h80,16'h2223, 2'b11, 1'b1,1'b0,1'b1,8'h80,16'h2222,1'b1,1'b0,16'd2,16'd2);
        vecs[7]  = mkv(1'b1,2'b00,8'h00,16'h0000, 2'b00,8'h00,16'h0000, 2'b11, 1'b0,1'b0,1'b1,8'h80,16'h1113,1'b0,1'b0,16'd3,16'd2);
        // pde burst 01,02,83 holds the output while pdae waits.
        vecs[8]  = mkv(1'b1,2'b11,8'h01,16'h0a01, 2'b00,8'h00,16'h0000, 2'b11, 1'b1,1'b0,1'b0,8'h80,16'h1113,1'b0,1'b1,16'd3,16'd2);
        vecs[9]  = mkv(1'b1,2'b11,8'h02,16'h0a02, 2'b11,8'h85,16'h0b00, 2'b11, 1'b1,1'b0,1'b1,8'h01,16'h0a01,1'b0,1'b0,16'd4,16'd2);
        vecs[10] = mkv(1'b1,2'b11,8'h83,16'h0a03, 2'b11,8'h85,16'h0b00, 2'b11, 1'b1,1'b0,1'b1,8'h02,16'h0a02,1'b0,1'b0,16'd5,16'd2);
        vecs[11] = mkv(1'b1,2'b00,8'h00,16'h0000, 2'b11,8'h85,16'h0b00, 2'b11, 1'b0,1'b1,1'b1,8'h83,16'h0a03,1'b0,1'b0,16'd6,16'd2);
        // ap_start low blocks grants; half-ready sources are never read.
        vecs[12] = mkv(1'b0,2'b11,8'h81,16'h0c00, 2'b11,8'h82,16'h0d00, 2'b11, 1'b0,1'b0,1'b1,8'h85,16'h0b00,1'b1,1'b0,16'd6,16'd3);
        vecs[13] = mkv(1'b1,2'b10,8'h81,16'h0c00, 2'b01,8'h82,16'h0d00, 2'b11, 1'b0,1'b0,1'b0,8'h85,16'h0b00,1'b1,1'b1,16'd6,16'd3);
        // ap_start dropped mid-burst: burst still completes.
        vecs[14] = mkv(1'b1,2'b11,8'h05,16'h0e05, 2'b00,8'h00,16'h0000, 2'b11, 1'b1,1'b0,1'b0,8'h85,16'h0b00,1'b1,1'b1,16'd6,16'd3);
        vecs[15] = mkv(1'b0,2'b11,8'h86,16'h0e06, 2'b11,8'h82,16'h0d00, 2'b11, 1'b1,1'b0,1'b1,8'h05,16'h0e05,1'b0,1'b0,16'd7,16'd3);
        vecs[16] = mkv(1'b0,2'b00,8'h00,16'h0000, 2'b00,8'h00,16'h0000, 2'b11, 1'b0,1'b0,1'b1,8'h86,16'h0e06,1'b0,1'b0,16'd8,16'd3);
        vecs[17] = mkv(1'b0,2'b00,8'h00,16'h0000, 2'b00,8'h00,16'h0000, 2'b11, 1'b0,1'b0,1'b0,8'h86,16'h0e06,1'b0,1'b1,16'd8,16'd3);
        // Back-pressure for 5 cycles, including one-sided full_n.
        vecs[18] = mkv(1'b1,2'b11,8'h81,16'h1234, 2'b00,8'h00,16'h0000, 2'b00, 1'b1,1'b0,1'b0,8'h86,16'h0e06,1'b0,1'b1,16'd8,16'd3);
        vecs[19] = mkv(1'b1,2'b11,8'h81,16'h1235, 2'b11,8'h82,16'h2235, 2'b00, 1'b0,1'b0,1'b0,8'h81,16'h1234,1'b0,1'b0,16'd9,16'd3);
        vecs[20] = mkv(1'b1,2'b11,8'h81,16'h1235, 2'b11,8'h82,16'h2235, 2'b10, 1'b0,1'b0,1'b0,8'h81,16'h1234,1'b0,1'b0,16'd9,16'd3);
        vecs[21] = mkv(1'b1,2'b11,8'h81,16'h1235, 2'b11,8'h82,16'h2235, 2'b01, 1'b0,1'b0,1'b0,8'h81,16'h1234,1'b0,1'b0,16'd9,16'd3);
        vecs[22] = mkv(1'b1,2'b11,8'h81,16'h1235, 2'b11,8'h82,16'h2235, 2'b00, 1'b0,1'b0,1'b0,8'h81,16'h1234,1'b0,1'b0,16'd9,16'd3);
        vecs[23] = mkv(1'b1,2'b11,8'h81,16'h1235, 2'b11,8'h82,16'h2235, 2'b00, 1'b0,1'b0,1'b0,8'h81,16'h1234,1'b0,1'b0,16'd9,16'd3);
        vecs[24] = mkv(1'b1,2'b11,8'h81,16'h1235, 2'b11,8'h82,16'h2235, 2'b11, 1'b0,1'b1,1'b1,8'h81,16'h1234,1'b0,1'b0,16'd9,16'd3);
        vecs[25] = mkv(1'b1,2'b11,8'h81,16'h1235, 2'b11,8'h82,16'h2236, 2'b11, 1'b1,1'b0,1'b1,8'h82,16'h2235,1'b1,1'b0,16'd9,16'd4);
        vecs[26] = mkv(1'b1,2'b00,8'h00,16'h0000, 2'b00,8'h00,16'h0000, 2'b11, 1'b0,1'b0,1'b1,8'h81,16'h1235,1'b0,1'b0,16'd10,16'd4);
        vecs[27] = mkv(1'b1,2'b00,8'h00,16'h0000, 2'b00,8'h00,16'h0000, 2'b11, 1'b0,1'b0,1'b0,8'h81,16'h1235,1'b0,1'b1,16'd10,16'd4);

        // Power-up reset and reset values.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #3 check("reset_values", expv(1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd0,16'd0));

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].st, vecs[i].pe, vecs[i].pc, vecs[i].pp,
                  vecs[i].qe, vecs[i].qc, vecs[i].qp, vecs[i].fn);
            #3 check($sformatf("vec%0d", i),
                     expv(vecs[i].rp, vecs[i].rq, vecs[i].wr, vecs[i].oc, vecs[i].op,
                          vecs[i].os, vecs[i].idle, vecs[i].cp, vecs[i].cq));
        end

        // Reset in the middle of a pde burst with a word still held.
        @(posedge clk); #1;
        drive(1'b1, 2'b11, 8'h01, 16'h3001, 2'b00, 8'h00, 16'h0000, 2'b11);
        #3 check("mid_burst_read", expv(1'b1,1'b0,1'b0,8'h81,16'h1235,1'b0,1'b1,16'd10,16'd4));
        @(posedge clk); #1;
        drive(1'b1, 2'b00, 8'h00, 16'h0000, 2'b11, 8'h85, 16'h5001, 2'b00);
        #3 check("mid_burst_lock", expv(1'b0,1'b0,1'b0,8'h01,16'h3001,1'b0,1'b0,16'd11,16'd4));
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1'b1, 2'b00, 8'h00, 16'h0000, 2'b00, 8'h00, 16'h0000, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_in();
        #3 check("rst_mid_burst", expv(1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd0,16'd0));
        // First tie after reset goes to pde, then pdae 0x85 is granted from IDLE.
        @(posedge clk); #1;
        drive(1'b1, 2'b11, 8'h80, 16'h4001, 2'b11, 8'h85, 16'h5001, 2'b11);
        #3 check("tie_after_rst", expv(1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0,1'b1,16'd0,16'd0));
        @(posedge clk); #1;
        drive(1'b1, 2'b11, 8'h80, 16'h4002, 2'b11, 8'h85, 16'h5001, 2'b11);
        #3 check("pdae_after_rst", expv(1'b0,1'b1,1'b1,8'h80,16'h4001,1'b0,1'b0,16'd1,16'd0));
        @(posedge clk); #1;
        idle_in();
        #3 check("pdae_written", expv(1'b0,1'b0,1'b1,8'h85,16'h5001,1'b1,1'b0,16'd1,16'd1));

        // 65537 single-word pde bursts: counter wraps through 0xFFFF to 1.
        reset_for(2);
        nrd = 0;
        for (int i = 0; i < 65537; i++) begin
            @(posedge clk); #1;
            drive(1'b1, 2'b11, 8'h81, 16'hffff, 2'b00, 8'h00, 16'h0000, 2'b11);
            #3;
            if (bus.pde_data_in_V_cnt_ls_V_read) nrd++;
            if (i == 65535)
                check("cnt_at_ffff", expv(1'b1,1'b0,1'b1,8'h81,16'hffff,1'b0,1'b0,16'hffff,16'd0));
        end
        @(posedge clk); #1;
        idle_in();
        #3 check("cnt_wrapped", expv(1'b0,1'b0,1'b1,8'h81,16'hffff,1'b0,1'b0,16'd1,16'd0));
        checks++;
        if (nrd != 65537) $display("FAIL wrap_reads: got %0d expected 65537", nrd);
        else              passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
